// File: rtl/rst_seq.sv
// rst_seq: supervises PLL lock and the clk_sys heartbeat, and issues the
// clk_sys reset request. All logic runs on clk_in.
//
// Ports:
//   clk_in       free-running board clock (only clock)
//   rst_n_inclk  asynchronous active-low reset
//   pll_locked   PLL lock flag (async, synchronized here)
//   clk_sys_hb   clk_sys heartbeat toggle (async, synchronized here)
//   rst_n_req    registered reset request, high only in RUN
//   state_o      WAIT_LOCK=0, SETTLE=1, RUN=2, FAULT=3
//   fault_cause  {hb timeout, lock loss}, latched on FAULT entry
//   fault_cnt    saturating count of FAULT entries
`timescale 1ns/1ps
module rst_seq #(
  parameter int LOCK_WAIT  = 1024,
  parameter int HB_TIMEOUT = 256,
  parameter int FAULT_HOLD = 64
) (
  input  logic       clk_in,
  input  logic       rst_n_inclk,
  input  logic       pll_locked,
  input  logic       clk_sys_hb,
  output logic       rst_n_req,
  output logic [1:0] state_o,
  output logic [1:0] fault_cause,
  output logic [7:0] fault_cnt
);

  localparam int LW_W = $clog2(LOCK_WAIT);
  localparam int HB_W = $clog2(HB_TIMEOUT);
  localparam int FH_W = $clog2(FAULT_HOLD);

  localparam logic [LW_W-1:0] LW_MAX =
    LW_W'(LOCK_WAIT - 1);
  localparam logic [HB_W-1:0] HB_MAX =
    HB_W'(HB_TIMEOUT - 1);
  localparam logic [FH_W-1:0] FH_MAX =
    FH_W'(FAULT_HOLD - 1);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    SETTLE    = 2'd1,
    RUN       = 2'd2,
    FAULT     = 2'd3
  } state_t;

  state_t r_state;
  state_t w_nxt;

  logic            r_lock_s1;
  logic            r_lock_s;
  logic            r_hb_s1;
  logic            r_hb_s2;
  logic            r_hb_h;
  logic [1:0]      r_hb_fill;
  logic [HB_W-1:0] r_hb_cnt;
  logic            r_hb_seen;
  logic [LW_W-1:0] r_settle_cnt;
  logic [FH_W-1:0] r_hold_cnt;
  logic            r_rst_n_req;
  logic [1:0]      r_cause;
  logic [7:0]      r_fcnt;

  logic w_hb_edge;
  logic w_lock_loss;
  logic w_timeout;
  logic w_to_settle;
  logic w_to_fault;

  // Edges are ignored until the sync chain and history flop have all
  // been loaded once after reset, so the initial level of clk_sys_hb
  // is never mistaken for a toggle.
  assign w_hb_edge = (r_hb_s2 ^ r_hb_h)
                   & (r_hb_fill == 2'd3);

  assign w_lock_loss = ~r_lock_s;
  assign w_timeout   = (r_hb_cnt == HB_MAX)
                     & ~w_hb_edge;

  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      WAIT_LOCK: begin
        if (r_lock_s) w_nxt = SETTLE;
      end
      SETTLE: begin
        if (!r_lock_s)
          w_nxt = WAIT_LOCK;
        else if (r_settle_cnt == LW_MAX &&
                 (r_hb_seen || w_hb_edge))
          w_nxt = RUN;
      end
      RUN: begin
        if (w_lock_loss || w_timeout)
          w_nxt = FAULT;
      end
      FAULT: begin
        if (r_hold_cnt == FH_MAX)
          w_nxt = WAIT_LOCK;
      end
      default: w_nxt = WAIT_LOCK;
    endcase
  end

  assign w_to_settle = (r_state == WAIT_LOCK) &&
                       (w_nxt == SETTLE);
  assign w_to_fault  = (r_state == RUN) &&
                       (w_nxt == FAULT);

  always_ff @(posedge clk_in or negedge rst_n_inclk) begin
    if (!rst_n_inclk) begin
      r_lock_s1 <= 1'b0;
      r_lock_s  <= 1'b0;
      r_hb_s1   <= 1'b0;
      r_hb_s2   <= 1'b0;
      r_hb_h    <= 1'b0;
      r_hb_fill <= 2'd0;
    end else begin
      r_lock_s1 <= pll_locked;
      r_lock_s  <= r_lock_s1;
      r_hb_s1   <= clk_sys_hb;
      r_hb_s2   <= r_hb_s1;
      r_hb_h    <= r_hb_s2;
      if (r_hb_fill != 2'd3)
        r_hb_fill <= r_hb_fill + 2'd1;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_inclk) begin
    if (!rst_n_inclk) begin
      r_hb_cnt <= '0;
    end else if (w_hb_edge) begin
      r_hb_cnt <= '0;
    end else if (r_hb_cnt != HB_MAX) begin
      r_hb_cnt <= r_hb_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_inclk) begin
    if (!rst_n_inclk) begin
      r_state      <= WAIT_LOCK;
      r_rst_n_req  <= 1'b0;
      r_settle_cnt <= '0;
      r_hb_seen    <= 1'b0;
      r_hold_cnt   <= '0;
      r_cause      <= 2'b00;
      r_fcnt       <= 8'd0;
    end else begin
      r_state     <= w_nxt;
      r_rst_n_req <= (w_nxt == RUN);

      if (w_to_settle) begin
        r_settle_cnt <= '0;
        r_hb_seen    <= 1'b0;
      end else if (r_state == SETTLE) begin
        if (r_settle_cnt != LW_MAX)
          r_settle_cnt <= r_settle_cnt + 1'b1;
        if (w_hb_edge)
          r_hb_seen <= 1'b1;
      end

      if (w_to_fault) begin
        r_hold_cnt <= '0;
        r_cause    <= {w_timeout, w_lock_loss};
        if (r_fcnt != 8'hff)
          r_fcnt <= r_fcnt + 8'd1;
      end else if (r_state == FAULT &&
                   r_hold_cnt != FH_MAX) begin
        r_hold_cnt <= r_hold_cnt + 1'b1;
      end
    end
  end

  assign rst_n_req   = r_rst_n_req;
  assign state_o     = r_state;
  assign fault_cause = r_cause;
  assign fault_cnt   = r_fcnt;

endmodule
